// File: rtl/dma_ep_pkg.sv
// Shared types and constants for the DMA I/O endpoint (dma_io_endpoint and its FIFO).
package dma_ep_pkg;

    localparam int DMA_DB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        TERM = 2'd3
    } ep_state_e;

    typedef enum logic {
        DEV2MEM = 1'b0,
        MEM2DEV = 1'b1
    } ep_dir_e;

endpackage

// File: rtl/dma_ep_fifo.sv
// Synchronous FIFO for the DMA endpoint: power-of-two depth, free-running
// pointers, occupancy counter one bit wider than the pointers.
module dma_ep_fifo
    import dma_ep_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = DMA_DB_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_io_endpoint.sv
// Peripheral side of the 8237A DREQ/DACK handshake, FIFO-backed.
// Define DMA_EP_PROTO_CHECK_EN to latch protocol violations on err.
module dma_io_endpoint
    import dma_ep_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int THRESH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                enable,
    input  logic                dir,
    input  logic                flush,
    output logic                dreq,
    input  logic                dack,
    input  logic                ior_n,
    input  logic                iow_n,
    input  logic                eop_n,
    input  logic [DMA_DB_W-1:0] db_in,
    output logic [DMA_DB_W-1:0] db_out,
    output logic                db_oe,
    input  logic                dev_wr_valid,
    output logic                dev_wr_ready,
    input  logic [DMA_DB_W-1:0] dev_wr_data,
    output logic                dev_rd_valid,
    input  logic                dev_rd_ready,
    output logic [DMA_DB_W-1:0] dev_rd_data,
    output logic                done,
    output logic                err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEP = CW'(DEPTH);
    localparam logic [CW-1:0] THR = CW'(THRESH);
    localparam logic [CW-1:0] ONE = CW'(1);

    ep_state_e           state_q, state_d;
    ep_dir_e             dir_q;
    logic                enable_q, armed_q, armed_d;
    logic                ior_q, iow_q, ior_bad_q, iow_bad_q;
    logic [DMA_DB_W-1:0] db_q;

    logic                full, empty, fifo_push, fifo_pop;
    logic [DMA_DB_W-1:0] fifo_wdata, head;
    logic [CW-1:0]       count, count_nxt, free, free_nxt;
    logic                dir0, enable_rise, ior_off, iow_off;
    logic                ior_rise, iow_rise, bus_pop, bus_push, dev_push, dev_pop;
    logic                start, cont_nxt, xfer, eop, strobe_idle;

    dma_ep_fifo #(.DEPTH(DEPTH), .W(DMA_DB_W)) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign dir0        = (dir_q == DEV2MEM);
    assign enable_rise = enable & ~enable_q;
    assign eop         = ~eop_n & dack;
    assign strobe_idle = ior_n & iow_n;

    // A strobe flagged while low is void for its whole pulse and moves no data.
    assign ior_off  = ~ior_n & (~dack | ~dir0 | empty);
    assign iow_off  = ~iow_n & (~dack | dir0 | full);
    assign ior_rise = ior_n & ~ior_q & dack & ~ior_bad_q;
    assign iow_rise = iow_n & ~iow_q & dack & ~iow_bad_q;
    assign bus_pop  = ior_rise & dir0 & ~empty;
    assign bus_push = iow_rise & ~dir0 & ~full;
    assign xfer     = bus_pop | bus_push;

    assign dev_wr_ready = dir0 & ~full;
    assign dev_rd_valid = ~dir0 & ~empty;
    assign dev_rd_data  = head;
    assign dev_push     = dev_wr_valid & dev_wr_ready;
    assign dev_pop      = dev_rd_valid & dev_rd_ready;

    assign fifo_push  = dev_push | bus_push;
    assign fifo_pop   = dev_pop | bus_pop;
    assign fifo_wdata = dir0 ? dev_wr_data : db_q;

    always_comb begin
        count_nxt = count;
        if (fifo_push && !fifo_pop)      count_nxt = count + ONE;
        else if (!fifo_push && fifo_pop) count_nxt = count - ONE;
    end

    assign free     = DEP - count;
    assign free_nxt = DEP - count_nxt;
    assign start    = dir0 ? ((count >= THR) | (flush & (count != '0))) : (free >= THR);
    assign cont_nxt = dir0 ? (count_nxt != '0) : (free_nxt != '0);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            IDLE: if (enable && armed_q && start) state_d = REQ;
            REQ: begin
                if (eop)                          state_d = TERM;
                else if (!enable && strobe_idle)  state_d = IDLE;
                else if (dack)                    state_d = XFER;
            end
            XFER: begin
                if (eop)                          state_d = TERM;
                else if (!enable && strobe_idle)  state_d = IDLE;
                else if (!dack)                   state_d = IDLE;
                else if (xfer && !cont_nxt)       state_d = IDLE;
            end
            TERM: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (enable_rise) armed_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            dir_q     <= DEV2MEM;
            enable_q  <= 1'b0;
            armed_q   <= 1'b0;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            ior_bad_q <= 1'b0;
            iow_bad_q <= 1'b0;
            db_q      <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            enable_q  <= enable;
            if (enable_rise) dir_q <= ep_dir_e'(dir);
            ior_q     <= ior_n;
            iow_q     <= iow_n;
            ior_bad_q <= ior_off | (ior_bad_q & ~ior_n);
            iow_bad_q <= iow_off | (iow_bad_q & ~iow_n);
            if (!iow_n) db_q <= db_in;
        end
    end

`ifdef DMA_EP_PROTO_CHECK_EN
    logic err_q;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) err_q <= 1'b0;
        else        err_q <= err_q | ior_off | iow_off;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dreq   = (state_q == REQ) || (state_q == XFER);
    assign done   = (state_q == TERM);
    // Gated by RESET so the bus is released the instant reset asserts.
    assign db_oe  = RESET & dack & ~ior_n & dir0;
    assign db_out = db_oe ? head : '0;

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Directed bench for dma_io_endpoint: bursts both ways, EOP, concurrent push/pop,
// protocol error, reset mid-burst.
module tb_dma_io_endpoint;

    logic       CLK, RESET, enable, dir, flush, dreq, dack;
    logic       ior_n, iow_n, eop_n, db_oe, done, err;
    logic [7:0] db_in, db_out, dev_wr_data, dev_rd_data;
    logic       dev_wr_valid, dev_wr_ready, dev_rd_valid, dev_rd_ready;

    int nvec = 0;
    int nmis = 0;

    dma_io_endpoint #(.DEPTH(16), .THRESH(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .enable       (enable),
        .dir          (dir),
        .flush        (flush),
        .dreq         (dreq),
        .dack         (dack),
        .ior_n        (ior_n),
        .iow_n        (iow_n),
        .eop_n        (eop_n),
        .db_in        (db_in),
        .db_out       (db_out),
        .db_oe        (db_oe),
        .dev_wr_valid (dev_wr_valid),
        .dev_wr_ready (dev_wr_ready),
        .dev_wr_data  (dev_wr_data),
        .dev_rd_valid (dev_rd_valid),
        .dev_rd_ready (dev_rd_ready),
        .dev_rd_data  (dev_rd_data),
        .done         (done),
        .err          (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dev_push(input logic [7:0] first, input int n);
        dev_wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            dev_wr_data = first + 8'(i);
            tick();
        end
        dev_wr_valid = 1'b0;
    endtask

    task automatic ior_rd(input string tag, input logic [31:0] exp);
        ior_n = 1'b0;
        #1;
        chk({tag, "_oe"}, 32'(db_oe), 1);
        chk(tag, 32'(db_out), exp);
        tick();
        ior_n = 1'b1;
        tick();
    endtask

    task automatic iow_wr(input logic [7:0] v);
        iow_n = 1'b0;
        db_in = v;
        tick();
        iow_n = 1'b1;
        db_in = 8'h00;
        tick();
    endtask

    initial begin
        RESET = 1'b0; enable = 1'b0; dir = 1'b0; flush = 1'b0; dack = 1'b0;
        ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1; db_in = 8'h00;
        dev_wr_valid = 1'b0; dev_wr_data = 8'h00; dev_rd_ready = 1'b0;
        tick(); tick();
        chk("rst_dreq",  32'(dreq), 0);
        chk("rst_db_oe", 32'(db_oe), 0);
        chk("rst_dbout", 32'(db_out), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_wrrdy", 32'(dev_wr_ready), 1);
        chk("rst_rdvld", 32'(dev_rd_valid), 0);
        RESET = 1'b1;
        tick();

        // dev->mem burst at threshold
        enable = 1'b1; dir = 1'b0;
        tick();
        dev_push(8'hA0, 4);
        chk("t1_dreq_pre", 32'(dreq), 0);
        tick();
        chk("t1_dreq_up", 32'(dreq), 1);
        dack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ior_rd($sformatf("t1_rd%0d", i), 32'hA0 + i);
            chk($sformatf("t1_dreq%0d", i), 32'(dreq), (i == 3) ? 0 : 1);
        end
        dack = 1'b0;

        // mem->dev fill to full, then device drain
        enable = 1'b0; tick();
        dir = 1'b1; enable = 1'b1; tick(); tick();
        chk("t2_dreq_up", 32'(dreq), 1);
        chk("t2_wrrdy", 32'(dev_wr_ready), 0);
        dack = 1'b1; tick();
        for (int i = 0; i < 16; i++) begin
            iow_wr(8'h10 + 8'(i));
            if (i >= 14) chk($sformatf("t2_dreq%0d", i), 32'(dreq), (i == 15) ? 0 : 1);
        end
        dack = 1'b0;
        dev_rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_vld%0d", i), 32'(dev_rd_valid), 1);
            chk($sformatf("t2_pop%0d", i), 32'(dev_rd_data), 32'h10 + i);
            tick();
        end
        dev_rd_ready = 1'b0;
        chk("t2_empty", 32'(dev_rd_valid), 0);

        // EOP during the 3rd IOR
        enable = 1'b0; tick();
        dir = 1'b0; enable = 1'b1; tick();
        dev_push(8'h30, 8);
        dack = 1'b1; tick();
        ior_rd("t3_rd0", 'h30);
        ior_rd("t3_rd1", 'h31);
        ior_n = 1'b0; eop_n = 1'b0;
        #1;
        chk("t3_rd2", 32'(db_out), 'h32);
        tick();
        ior_n = 1'b1; eop_n = 1'b1;
        #1;
        chk("t3_done", 32'(done), 1);
        chk("t3_dreq_term", 32'(dreq), 0);
        tick();
        chk("t3_done_off", 32'(done), 0);
        dack = 1'b0;
        tick(); tick(); tick();
        chk("t3_no_rearm", 32'(dreq), 0);
        enable = 1'b0; tick();
        enable = 1'b1; tick(); tick();
        chk("t3_rearm", 32'(dreq), 1);

        // simultaneous device push and IOR pop at count 5
        dack = 1'b1; tick();
        ior_n = 1'b0;
        #1;
        chk("t4_rd0", 32'(db_out), 'h33);
        tick();
        ior_n = 1'b1; dev_wr_valid = 1'b1; dev_wr_data = 8'h38;
        #1;
        chk("t4_wrrdy", 32'(dev_wr_ready), 1);
        tick();
        dev_wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ior_rd($sformatf("t4_rd%0d", i + 1), 32'h34 + i);
            chk($sformatf("t4_dreq%0d", i), 32'(dreq), (i == 4) ? 0 : 1);
        end
        dack = 1'b0;

        // IOR without DACK
        dev_push(8'h50, 2);
        ior_n = 1'b0; tick();
        ior_n = 1'b1; tick();
`ifdef DMA_EP_PROTO_CHECK_EN
        chk("t5_err", 32'(err), 1);
`else
        chk("t5_err", 32'(err), 0);
`endif
        chk("t5_dreq_idle", 32'(dreq), 0);
        flush = 1'b1; tick();
        chk("t5_flush_dreq", 32'(dreq), 1);
        dack = 1'b1; tick();
        ior_rd("t5_rd0", 'h50);
        ior_rd("t5_rd1", 'h51);
        chk("t5_dreq_end", 32'(dreq), 0);
        flush = 1'b0; dack = 1'b0; tick();

        // reset mid-burst
        dev_push(8'h60, 6);
        tick();
        dack = 1'b1; tick();
        ior_n = 1'b0;
        #1;
        chk("t6_oe_pre", 32'(db_oe), 1);
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_dreq", 32'(dreq), 0);
        chk("t6_db_oe", 32'(db_oe), 0);
        chk("t6_dbout", 32'(db_out), 0);
        chk("t6_done", 32'(done), 0);
        dack = 1'b0; ior_n = 1'b1;
        tick(); tick();
        RESET = 1'b1;
        tick();
        chk("t6_wrrdy", 32'(dev_wr_ready), 1);
        chk("t6_rdvld", 32'(dev_rd_valid), 0);
        chk("t6_err", 32'(err), 0);
        flush = 1'b1;
        tick(); tick(); tick();
        chk("t6_empty_no_dreq", 32'(dreq), 0);
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dma_io_endpoint.md
# dma_io_endpoint

Peripheral-side end of the 8237A DREQ/DACK handshake: a FIFO-backed I/O endpoint that raises DREQ toward the DMA controller and services its IOR/IOW strobes while DACK is asserted. It bridges a device-side valid/ready stream to the DMA bus data path and honours EOP termination. It is used as the bench responder for the controller and as the reusable DMA front end of on-chip peripherals.

## Interface
- DEPTH, 16: FIFO entries, power of two, ≥4.
- THRESH, 4: fill (dir 0) or free-space (dir 1) level that first raises DREQ, 1..DEPTH.
- CLK  in  1  system clock; all strobes are synchronous to it.
- RESET  in  1  asynchronous, active-low reset.
- enable  in  1  arms endpoint; rising edge latches dir.
- dir  in  1  0 = device→memory (IOR cycles), 1 = memory→device (IOW cycles).
- flush  in  1  dir 0 only: request DREQ for any count >0 below THRESH.
- dreq  out  1  DMA request, active-high.
- dack  in  1  DMA acknowledge, active-high.
- ior_n  in  1  I/O read strobe, active-low.
- iow_n  in  1  I/O write strobe, active-low.
- eop_n  in  1  end of process, active-low.
- db_in  in  8  bus data, sampled on IOW.
- db_out  out  8  bus data, driven on IOR.
- db_oe  out  1  db_out enable.
- dev_wr_valid / dev_wr_ready / dev_wr_data  in/out/in  1/1/8  device push (dir 0).
- dev_rd_valid / dev_rd_ready / dev_rd_data  out/in/out  1/1/8  device pop (dir 1).
- done  out  1  one-cycle pulse on EOP termination.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, REQ, XFER, TERM.
- IDLE: dreq 0. Go to REQ when enable=1, armed and the start condition holds. Start condition: dir 0, count ≥THRESH or (flush and count>0); dir 1, free ≥THRESH.
- REQ: dreq 1. Go to XFER when dack=1. dreq is never withdrawn before dack.
- XFER: dreq stays 1 while data remains: dir 0, count>0; dir 1, free>0. Each strobe trailing edge (low→high while dack=1) is one transfer.
  - IOR: pop at the trailing edge.
  - IOW: push the db_in value registered on the last low cycle.
  - When the continue condition fails after a transfer, or dack drops, go to IDLE.
- eop_n=0 with dack=1 in REQ or XFER: go to TERM and complete any strobe trailing in the same cycle. TERM pulses done, clears armed and returns to IDLE. armed is set again only by an enable 0→1.
- enable=0 in any state: go to IDLE after the current strobe completes. FIFO contents are kept.
- db_oe = dack & ~ior_n & (dir==0); db_out = FIFO head, else 0.
- Device-side handshakes:
  - dev_wr_ready = (dir_q==0) & ~full.
  - dev_rd_valid = (dir_q==1) & ~empty.
  - Push and pop in the same cycle leave count unchanged.
- count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

## Timing
- Reset values: dreq 0, db_oe 0, db_out 0, done 0, err 0, state IDLE, FIFO empty, dir_q 0, armed 0. So dev_wr_ready=1 and dev_rd_valid=0 after reset.
- dreq is registered: it rises 1 cycle after the start condition is first true.
- dreq falls on the cycle after the trailing edge that exhausts data or space.
- db_out and db_oe are combinational from dack/ior_n and the head, so data is valid in the same cycle as ior_n low.
- done pulses for exactly one cycle, the cycle after eop_n is sampled low.
- Reset mid-burst: all outputs return to reset values immediately, regardless of CLK.

## Configuration
- DMA_EP_PROTO_CHECK_EN defined:
  - err sets on any of: a strobe while dack=0; ior_n low in dir 1; iow_n low in dir 0; IOR on empty; IOW on full.
  - Offending strobes move no data.
  - err clears only on RESET.
- Undefined: err is tied 0. The same strobes are silently ignored.

## Structure
- Package dma_ep_pkg holds:
  - the state enum (IDLE, REQ, XFER, TERM);
  - a dir enum (DEV2MEM, MEM2DEV);
  - the bus width constant DMA_DB_W=8.
- One sub-module, dma_ep_fifo: synchronous FIFO with push/pop/full/empty/count, reset-cleared pointers.

## Test plan
- dir 0, THRESH 4: push 4 bytes 0xA0..0xA3 → dreq rises 1 cycle later. dack plus 4 IOR strobes return A0..A3 on db_out. dreq falls after the 4th trailing edge.
- dir 1, DEPTH 16: 16 IOW strobes of 0x10..0x1F fill the FIFO and drop dreq. Device pops 0x10..0x1F in order.
- dir 0, 8 bytes queued: eop_n low with dack during the 3rd IOR → 3 bytes transferred, done pulse, dreq 0. No new dreq until enable is toggled.
- Simultaneous device push and IOR pop at count 5 → count stays 5 and data order is preserved.
- With DMA_EP_PROTO_CHECK_EN: ior_n low with dack=0 → err=1 and count unchanged. Without the macro: err stays 0.
- RESET asserted mid-burst → dreq, db_oe and done are 0 immediately, and the FIFO is empty after release.
